// File: rtl/sub4_serial.sv
// Bit-serial subtractor D = inA - inB, LSB first, one full-subtractor cell per clock.
// Latency WIDTH+1 cycles from the accepting start edge to done; start is ignored while busy or done.
module sub4_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             is_overflowed
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [WIDTH-1:0] a_lat, b_lat;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             d_bit;
   logic             br_nxt;
   logic             last_bit;
   logic [WIDTH-1:0] res_nxt;

   always_comb begin
      d_bit    = a_sr[0] ^ b_sr[0] ^ br;
      br_nxt   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      res_nxt  = {d_bit, res_sr[WIDTH-1:1]};
      last_bit = (cnt == CW'(WIDTH-1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The final bit is folded straight into the outputs on the DONE entry edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr          <= '0;
         b_sr          <= '0;
         res_sr        <= '0;
         a_lat         <= '0;
         b_lat         <= '0;
         br            <= 1'b0;
         cnt           <= '0;
         diff          <= '0;
         bout          <= 1'b0;
         is_overflowed <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= inA;
                  b_sr  <= inB;
                  a_lat <= inA;
                  b_lat <= inB;
                  br    <= 1'b0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nxt;
               br     <= br_nxt;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  diff          <= res_nxt;
                  bout          <= br_nxt;
                  is_overflowed <= (a_lat[WIDTH-1] != b_lat[WIDTH-1]) &&
                                   (res_nxt[WIDTH-1] != a_lat[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub4_serial.sv
// Self-checking bench for sub4_serial against an arithmetic reference of A-B.
module tb_sub4_serial;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] inA, inB;
   logic         busy, done;
   logic [W-1:0] diff;
   logic         bout, is_overflowed;

   int n_chk = 0;
   int n_fail = 0;

   sub4_serial #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB),
      .busy(busy), .done(done), .diff(diff), .bout(bout),
      .is_overflowed(is_overflowed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain modular and signed integer arithmetic.
   function automatic logic [W-1:0] ref_diff(input int a, input int b);
      int r;
      r = (a - b) & ((1 << W) - 1);
      return W'(r);
   endfunction

   function automatic logic ref_bout(input int a, input int b);
      return a < b;
   endfunction

   function automatic logic ref_ovf(input int a, input int b);
      int sa, sb, r;
      sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
      r  = sa - sb;
      return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
   endfunction

   // Runs one operation from IDLE and checks latency and results; returns in IDLE.
   task automatic do_op(input string tag, input int a, input int b);
      int lat;
      start = 1'b1;
      inA   = W'(a);
      inB   = W'(b);
      tick();
      start = 1'b0;
      inA   = W'($urandom);
      inB   = W'($urandom);
      lat   = 1;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, W + 1);
      chk({tag, "_diff"}, diff, ref_diff(a, b));
      chk({tag, "_bout"}, bout, ref_bout(a, b));
      chk({tag, "_ovf"}, is_overflowed, ref_ovf(a, b));
      tick();
   endtask

   initial begin
      int a0, b0, prev_done, lat;
      logic [W-1:0] prev_diff;

      rst = 1'b1; start = 1'b0; inA = '0; inB = '0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", is_overflowed, 0);
      rst = 1'b0;
      tick();

      do_op("t1", 4'b0101, 4'b0011);
      do_op("t2", 4'b0011, 4'b0101);
      do_op("t3a", 4'b0111, 4'b1111);
      do_op("t3b", 4'b1000, 4'b0001);

      // Outputs hold in IDLE and through the next RUN.
      tick();
      chk("hold_idle", diff, 4'b0111);
      chk("hold_ovf", is_overflowed, 1);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            do_op("sweep", a, b);

      for (int i = 0; i < 40; i++)
         do_op("rand", int'($urandom_range(15)), int'($urandom_range(15)));

      // T5: start held high, operands churn during RUN.
      prev_diff = diff;
      a0 = int'($urandom_range(15));
      b0 = int'($urandom_range(15));
      start = 1'b1; inA = W'(a0); inB = W'(b0);
      tick();
      lat = 1; prev_done = 0;
      while (!done && lat < 20) begin
         chk("t5_busy", busy, 1);
         if (lat == 2) chk("t5_hold_run", diff, prev_diff);
         inA = W'($urandom); inB = W'($urandom);
         tick();
         lat++;
      end
      chk("t5_lat", lat, W + 1);
      chk("t5_diff", diff, ref_diff(a0, b0));
      chk("t5_bout", bout, ref_bout(a0, b0));
      chk("t5_ovf", is_overflowed, ref_ovf(a0, b0));
      start = 1'b0;
      tick();
      chk("t5_no_dbl_done", done, 0);
      chk("t5_idle_busy", busy, 0);
      tick();

      // T6: reset during the second RUN cycle.
      start = 1'b1; inA = 4'b1010; inB = 4'b0011;
      tick();
      start = 1'b0;
      tick();
      chk("t6_run2_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_diff", diff, 0);
      chk("t6_bout", bout, 0);
      chk("t6_ovf", is_overflowed, 0);
      prev_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) prev_done = 1;
         tick();
      end
      chk("t6_no_done", prev_done, 0);
      do_op("t6_fresh", 4'b0110, 4'b0001);
      chk("t6_fresh_val", diff, 4'b0101);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   // done must never be high on two consecutive cycles.
   logic done_q = 1'b0;
   always @(negedge clk) begin
      if (done && done_q) chk("done_consecutive", 1, 0);
      done_q <= done;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
